// File: rtl/moka_rv32i_fetch_stage.sv
// RV32I IF stage with IF/ID register: single-outstanding imem handshake, redirect/drop FSM, 1-entry D-stall buffer.
// Optional: define MOKA_FETCH_MISALIGN_EN to add MisalignF and suppress fetches after a misaligned redirect.
module moka_rv32i_fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000),
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef MOKA_FETCH_MISALIGN_EN
    output logic                  MisalignF,
`endif
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
);

    typedef enum logic [0:0] {S_REQ = 1'b0, S_DROP = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic                    run_q;
    logic                    pending_q, pending_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   pcf_q, pcf_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [DATA_WIDTH-1:0]   buf_instr_q, buf_instr_d;
    logic [DATA_WIDTH-1:0]   buf_pc_q, buf_pc_d;
    logic [DATA_WIDTH-1:0]   instrd_q, instrd_d;
    logic [DATA_WIDTH-1:0]   pcd_q, pcd_d;
    logic [DATA_WIDTH-1:0]   pcplus4d_q, pcplus4d_d;
    logic                    validd_q, validd_d;
    logic                    misalign_q;
    logic [DATA_WIDTH-1:0]   target;
    logic                    accept;

`ifdef MOKA_FETCH_MISALIGN_EN
    assign target = PCTargetE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      misalign_q <= 1'b0;
        else if (PCSrcE) misalign_q <= (target[1:0] != 2'b00);
    end

    assign MisalignF = misalign_q;
`else
    assign target     = PCTargetE & ~DATA_WIDTH'(3);
    assign misalign_q = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_REQ;
        else        state_q <= state_d;
    end

    // FSM next state: a redirect that catches an unanswered request must drain it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:   if (PCSrcE && imem_req && !imem_rvalid) state_d = S_DROP;
            S_DROP:  if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // FSM outputs: the address is frozen once a request has been presented
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pending_q ? addr_q : pcf_q;
        unique case (state_q)
            S_REQ:   imem_req = run_q & (pending_q | (~StallF & ~buf_valid_q & ~misalign_q));
            S_DROP:  imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    assign accept = (state_q == S_REQ) & imem_req & imem_rvalid & ~PCSrcE;

    // PC, holding buffer and IF/ID next state
    always_comb begin
        pending_d   = imem_req & ~imem_rvalid;
        addr_d      = imem_addr;
        pcf_d       = pcf_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instrd_d    = instrd_q;
        pcd_d       = pcd_q;
        pcplus4d_d  = pcplus4d_q;
        validd_d    = validd_q;

        if (PCSrcE) begin
            pcf_d       = target;
            buf_valid_d = 1'b0;
        end else begin
            if (accept) pcf_d = pcf_q + DATA_WIDTH'(4);
            if (accept && StallD && !FlushD) begin
                buf_valid_d = 1'b1;
                buf_instr_d = imem_rdata;
                buf_pc_d    = imem_addr;
            end else if (buf_valid_q && !StallD && !FlushD) begin
                buf_valid_d = 1'b0;
            end
        end

        if (FlushD) begin
            instrd_d = NOP_INSTR;
            validd_d = 1'b0;
        end else if (!StallD) begin
            if (buf_valid_q && !PCSrcE) begin
                instrd_d   = buf_instr_q;
                pcd_d      = buf_pc_q;
                pcplus4d_d = buf_pc_q + DATA_WIDTH'(4);
                validd_d   = 1'b1;
            end else if (accept) begin
                instrd_d   = imem_rdata;
                pcd_d      = imem_addr;
                pcplus4d_d = imem_addr + DATA_WIDTH'(4);
                validd_d   = 1'b1;
            end else begin
                instrd_d = NOP_INSTR;
                validd_d = 1'b0;
            end
        end
    end

    // Datapath registers; run_q keeps imem_req low until reset has been released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            pending_q   <= 1'b0;
            addr_q      <= RESET_PC;
            pcf_q       <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= '0;
            instrd_q    <= NOP_INSTR;
            pcd_q       <= '0;
            pcplus4d_q  <= '0;
            validd_q    <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            pending_q   <= pending_d;
            addr_q      <= addr_d;
            pcf_q       <= pcf_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instrd_q    <= instrd_d;
            pcd_q       <= pcd_d;
            pcplus4d_q  <= pcplus4d_d;
            validd_q    <= validd_d;
        end
    end

    assign PCF      = pcf_q;
    assign PCPlus4F = pcf_q + DATA_WIDTH'(4);
    assign InstrD   = instrd_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcplus4d_q;
    assign ValidD   = validd_q;

endmodule

// File: tb/tb_moka_rv32i_fetch_stage.sv
// Directed bench for moka_rv32i_fetch_stage with a latency-programmable instruction memory model.
module tb_moka_rv32i_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF, StallD, FlushD;
    logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef MOKA_FETCH_MISALIGN_EN
    logic        MisalignF;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int cnt;

    localparam logic [31:0] NOP = 32'h0000_0013;

    moka_rv32i_fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MOKA_FETCH_MISALIGN_EN
        .MisalignF(MisalignF),
`endif
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0060_0113;
            32'h0000_0008: return 32'hDEAD_0008;
            32'h0000_000C: return 32'h00A0_0193;
            default:       return 32'h5A5A_0000 ^ a;
        endcase
    endfunction

    // Memory answers after 'lat' cycles of continuous request (lat=1 is zero-wait)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      cnt <= 0;
        else if (imem_req && !imem_rvalid) cnt <= cnt + 1;
        else                             cnt <= 0;
    end
    assign imem_rvalid = imem_req && (cnt >= lat - 1);
    always_comb imem_rdata = mem_fn(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst_n = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; lat = l;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; lat = 1;
        step(); step();
        n_tests++;
        if (imem_req !== 1'b0 || ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 ||
            PCPlus4D !== 32'h0 || PCF !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: req=%b valid=%b instr=%h pcd=%h pc4d=%h pcf=%h required 0/0/%h/0/0/0",
                     imem_req, ValidD, InstrD, PCD, PCPlus4D, PCF, NOP);
        end
    endtask

    task automatic test_zero_wait();
        do_reset(1);
        step();
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL zw_req0: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        end
        step();
        n_tests++;
        if (InstrD !== 32'h0050_0093 || PCD !== 32'h0 || ValidD !== 1'b1 || imem_addr !== 32'h4) begin
            n_fail++; $display("FAIL zw_first: instr=%h pcd=%h valid=%b addr=%h required 00500093/0/1/4",
                               InstrD, PCD, ValidD, imem_addr);
        end
        step();
        n_tests++;
        if (InstrD !== 32'h0060_0113 || PCD !== 32'h4 || PCPlus4D !== 32'h8 || ValidD !== 1'b1) begin
            n_fail++; $display("FAIL zw_second: instr=%h pcd=%h pc4d=%h valid=%b required 00600113/4/8/1",
                               InstrD, PCD, PCPlus4D, ValidD);
        end
    endtask

    task automatic test_latency();
        do_reset(3);
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ValidD !== 1'b0) begin
                n_fail++; $display("FAIL lat_hold%0d: req=%b addr=%h valid=%b required 1/0/0",
                                   i, imem_req, imem_addr, ValidD);
            end
        end
        step();
        n_tests++;
        if (ValidD !== 1'b1 || InstrD !== 32'h0050_0093 || imem_addr !== 32'h4) begin
            n_fail++; $display("FAIL lat_first: valid=%b instr=%h addr=%h required 1/00500093/4",
                               ValidD, InstrD, imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (ValidD !== 1'b0) begin
                n_fail++; $display("FAIL lat_gap%0d: valid=%b required 0", i, ValidD);
            end
        end
        step();
        n_tests++;
        if (ValidD !== 1'b1 || InstrD !== 32'h0060_0113 || PCD !== 32'h4) begin
            n_fail++; $display("FAIL lat_second: valid=%b instr=%h pcd=%h required 1/00600113/4",
                               ValidD, InstrD, PCD);
        end
    endtask

    task automatic test_redirect_drop();
        bit seen8;
        bit got;
        do_reset(1);
        step(); step(); step();
        lat = 3;
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        step();
        PCSrcE = 1'b0; PCTargetE = '0;
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || PCF !== 32'h40) begin
            n_fail++; $display("FAIL drop_hold: req=%b addr=%h pcf=%h required 1/8/40", imem_req, imem_addr, PCF);
        end
        seen8 = 1'b0; got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (ValidD && InstrD == 32'hDEAD_0008) seen8 = 1'b1;
            if (ValidD) got = 1'b1;
        end
        n_tests++;
        if (!got || seen8 || InstrD !== (32'h5A5A_0000 ^ 32'h40) || PCD !== 32'h40) begin
            n_fail++; $display("FAIL drop_target: got=%b seen8=%b instr=%h pcd=%h required 1/0/%h/40",
                               got, seen8, InstrD, PCD, 32'h5A5A_0000 ^ 32'h40);
        end
    endtask

    task automatic test_stall_buffer();
        do_reset(1);
        step(); step(); step(); step();
        StallD = 1'b1;
        step();
        n_tests++;
        if (imem_req !== 1'b0 || InstrD !== 32'hDEAD_0008 || PCF !== 32'h10) begin
            n_fail++; $display("FAIL stall_full: req=%b instr=%h pcf=%h required 0/dead0008/10",
                               imem_req, InstrD, PCF);
        end
        step();
        StallD = 1'b0;
        n_tests++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_noreq: req=%b required 0", imem_req);
        end
        step();
        n_tests++;
        if (InstrD !== 32'h00A0_0193 || PCD !== 32'hC || ValidD !== 1'b1 || imem_req !== 1'b1 ||
            imem_addr !== 32'h10) begin
            n_fail++; $display("FAIL stall_drain: instr=%h pcd=%h valid=%b req=%b addr=%h required 00a00193/c/1/1/10",
                               InstrD, PCD, ValidD, imem_req, imem_addr);
        end
    endtask

    task automatic test_flush_stall();
        do_reset(1);
        step(); step();
        FlushD = 1'b1; StallD = 1'b1;
        step();
        FlushD = 1'b0; StallD = 1'b0;
        n_tests++;
        if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0) begin
            n_fail++; $display("FAIL flush_stall: instr=%h valid=%b pcd=%h required 00000013/0/0",
                               InstrD, ValidD, PCD);
        end
    endtask

    task automatic test_wrap();
        do_reset(1);
        step();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        step();
        PCSrcE = 1'b0; PCTargetE = '0;
        n_tests++;
        if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0 || imem_addr !== 32'hFFFF_FFFC || ValidD !== 1'b0) begin
            n_fail++; $display("FAIL wrap_pcf: pcf=%h pc4f=%h addr=%h valid=%b required fffffffc/0/fffffffc/0",
                               PCF, PCPlus4F, imem_addr, ValidD);
        end
        step();
        n_tests++;
        if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || imem_addr !== 32'h0 || ValidD !== 1'b1) begin
            n_fail++; $display("FAIL wrap_next: pcd=%h pc4d=%h addr=%h valid=%b required fffffffc/0/0/1",
                               PCD, PCPlus4D, imem_addr, ValidD);
        end
    endtask

`ifdef MOKA_FETCH_MISALIGN_EN
    task automatic test_misalign();
        do_reset(1);
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h42;
        step();
        PCSrcE = 1'b0; PCTargetE = '0;
        step();
        n_tests++;
        if (MisalignF !== 1'b1 || imem_req !== 1'b0 || PCF !== 32'h42 || ValidD !== 1'b0) begin
            n_fail++; $display("FAIL misalign_set: mis=%b req=%b pcf=%h valid=%b required 1/0/42/0",
                               MisalignF, imem_req, PCF, ValidD);
        end
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        step();
        PCSrcE = 1'b0; PCTargetE = '0;
        n_tests++;
        if (MisalignF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL misalign_clr: mis=%b req=%b addr=%h required 0/1/40",
                               MisalignF, imem_req, imem_addr);
        end
    endtask
`else
    task automatic test_target_align();
        do_reset(1);
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h42;
        step();
        PCSrcE = 1'b0; PCTargetE = '0;
        n_tests++;
        if (PCF !== 32'h40 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL target_align: pcf=%h req=%b addr=%h required 40/1/40",
                               PCF, imem_req, imem_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_redirect_drop();
        test_stall_buffer();
        test_flush_stall();
        test_wrap();
`ifdef MOKA_FETCH_MISALIGN_EN
        test_misalign();
`else
        test_target_align();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/moka_rv32i_fetch_stage.md
Name: moka_rv32i_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Owns the PC (PCF) and runs a single-outstanding request/response handshake to instruction memory.
- Applies branch/jump redirects from EX (PCSrcE/PCTargetE) and StallF/StallD/FlushD from the hazard unit.
- Feeds decode with InstrD, PCD and PCPlus4D; has a 1-entry holding buffer so a response that arrives during a D stall is never lost.

Parameters:
DATA_WIDTH, 32, datapath/address width
RESET_PC, 32'h0000_0000, PCF value after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  DATA_WIDTH  fetch address; stable while a request is pending
imem_rvalid  in  1  response valid; completes the pending request
imem_rdata  in  DATA_WIDTH  fetched instruction
PCSrcE  in  1  redirect from EX
PCTargetE  in  DATA_WIDTH  redirect target
StallF  in  1  hazard: do not start a new fetch
StallD  in  1  hazard: hold IF/ID register
FlushD  in  1  hazard: load bubble into IF/ID
PCF  out  DATA_WIDTH  current fetch PC
PCPlus4F  out  DATA_WIDTH  PCF+4, mod 2^32
InstrD  out  DATA_WIDTH  instruction to decode
PCD  out  DATA_WIDTH  PC of InstrD
PCPlus4D  out  DATA_WIDTH  PCD+4
ValidD  out  1  InstrD is a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst_n=0):
  - PCF=RESET_PC, state=REQ, pending=0, buffer empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, imem_req=0.
- Handshake:
  - A request starts when imem_req=1; imem_addr=PCF.
  - Once started, the request stays high with a stable address until imem_rvalid=1 (the same cycle or later).
  - At most one request is outstanding. Zero-wait memory (rvalid in the request cycle) sustains 1 instr/cycle.
- FSM states REQ, DROP:
  - REQ: imem_req = pending | (!StallF & !buf_valid). On rvalid, capture the instruction and set PCF<=PCF+4.
  - DROP: entered when PCSrcE=1 while a request is pending and rvalid=0. imem_req stays 1 with the old address. On rvalid, discard the data and go to REQ with PCF already equal to the target.
- Redirect:
  - PCSrcE=1 → PCF<=PCTargetE next cycle and buf_valid<=0.
  - A same-cycle rvalid is discarded with no DROP needed; state goes to REQ.
  - Redirect wins over the PC+4 advance.
- Capture destination when rvalid arrives in REQ and PCSrcE=0:
  - StallD=0 and FlushD=0 → IF/ID register (1-cycle latency: rvalid at cycle t → ValidD=1 at t+1).
  - StallD=1 → holding buffer (buf_valid=1).
  - FlushD=1 → discarded.
- IF/ID register update, priority FlushD > StallD > load:
  - FlushD=1: bubble (InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D unchanged).
  - StallD=1: hold.
  - Otherwise load the buffer if buf_valid=1 (buffer empties), else the rvalid data, else a bubble.
- Buffer full: no new request is started; PCF already points past the buffered instruction.
- Buffer pointer: PCD is taken from the PC captured with the instruction, not from PCF.
- PCPlus4F/PCPlus4D wrap mod 2^32: PC 32'hFFFF_FFFC → 32'h0000_0000.
- Reset mid-transaction: the request is abandoned. Imem must tolerate imem_req dropping on reset.

Optional Feature:
- Macro MOKA_FETCH_MISALIGN_EN.
- Defined:
  - Adds output MisalignF (1 bit, reset 0).
  - A redirect with PCTargetE[1:0]!=0 sets MisalignF=1 and loads PCF=target, but no request is issued. D receives bubbles.
  - MisalignF clears on the next aligned redirect or on reset.
- Undefined: PCTargetE[1:0] is ignored and forced to 2'b00 when loaded into PCF.

Test Plan:
- Reset release with zero-wait memory returning 0x00500093, 0x00600113 → imem_addr 0x0, 0x4; InstrD=0x00500093/PCD=0x0 then 0x00600113/PCD=0x4; ValidD=1 each cycle.
- 3-cycle memory latency → imem_addr held 0x0 for 3 cycles; one instruction every 3 cycles; ValidD=0 between them.
- PCSrcE=1, PCTargetE=0x40 while a request to 0x8 is pending (rvalid 2 cycles later) → FSM enters DROP; the 0x8 data is never seen in InstrD; next request is 0x40; PCD=0x40.
- StallD=1 when rvalid returns 0x00A00193 for PC 0xC → no new request while the buffer is full; after StallD drops, InstrD=0x00A00193, PCD=0xC.
- FlushD=1 and StallD=1 together → InstrD=0x00000013, ValidD=0.
- PC at 0xFFFFFFFC → PCPlus4F=0x0 and the next fetch is 0x0. With MOKA_FETCH_MISALIGN_EN defined, redirect to 0x42 → MisalignF=1 and imem_req=0.
